// File: rtl/bin_dec_pkg.sv
// Shared types and constants for the binary decoder stream block.
// Holds the decode mode enum, active-level names and counter width.
package bin_dec_pkg;

  typedef enum logic {
    DEC_ONEHOT = 1'b0,
    DEC_THERM  = 1'b1
  } dec_mode_t;

  localparam int   DEC_CNT_W = 16;
  localparam logic ACT_HIGH  = 1'b1;
  localparam logic ACT_LOW   = 1'b0;

endpackage

// File: rtl/bin_dec_core.sv
// Combinational decoder: binary code -> one-hot or thermometer vector.
// Ports: in (code), mode (dec_mode_t), vec (decoded), err (in >= OUT).
module bin_dec_core
  import bin_dec_pkg::*;
#(
  parameter int   IN  = 4,
  parameter int   OUT = 1 << IN,
  parameter logic ACT = ACT_HIGH
) (
  input  logic [IN-1:0]  in,
  input  dec_mode_t      mode,
  output logic [OUT-1:0] vec,
  output logic           err
);

  always_comb begin
    // One extra bit so OUT == 1<<IN compares correctly.
    err = ({1'b0, in} >= (IN+1)'(OUT));
    vec = {OUT{~ACT}};
    if (!err) begin
      for (int i = 0; i < OUT; i++) begin
        if (mode == DEC_THERM)
          vec[i] = (IN'(i) <= in) ? ACT : ~ACT;
        else
          vec[i] = (IN'(i) == in) ? ACT : ~ACT;
      end
    end
  end

endmodule

// File: rtl/bin_dec_stream.sv
// Valid/ready decoder stream with a 2-entry result FIFO.
// Ports: clk, reset (sync, high), in_valid/in_ready/in/mode,
// out_valid/out_ready/out/out_err; dec_cnt when
// BIN_DEC_STREAM_CNT_EN is defined (good-result transfer count).
module bin_dec_stream
  import bin_dec_pkg::*;
#(
  parameter int   IN  = 4,
  parameter int   OUT = 1 << IN,
  parameter logic ACT = ACT_HIGH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IN-1:0]  in,
  input  logic           mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OUT-1:0] out,
  output logic           out_err
`ifdef BIN_DEC_STREAM_CNT_EN
  ,
  output logic [DEC_CNT_W-1:0] dec_cnt
`endif
);

  typedef struct packed {
    logic           err;
    logic [OUT-1:0] vec;
  } ent_t;

  ent_t           s0, s1, nw;
  logic [1:0]     cnt, cnt_nx;
  logic           rdy_q;
  logic           push, pop;
  logic [OUT-1:0] dvec;
  logic           derr;

  bin_dec_core #(
    .IN (IN),
    .OUT(OUT),
    .ACT(ACT)
  ) u_core (
    .in  (in),
    .mode(dec_mode_t'(mode)),
    .vec (dvec),
    .err (derr)
  );

  assign nw = {derr, dvec};

  // Gating with reset keeps the handshake dead in the reset cycle.
  assign in_ready  = rdy_q && !reset;
  assign out_valid = (cnt != 2'd0) && !reset;
  assign out       = out_valid ? s0.vec : {OUT{~ACT}};
  assign out_err   = out_valid && s0.err;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    cnt_nx = cnt;
    if (push && !pop)
      cnt_nx = cnt + 2'd1;
    else if (pop && !push)
      cnt_nx = cnt - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= 2'd0;
      rdy_q <= 1'b1;
    end else begin
      cnt   <= cnt_nx;
      rdy_q <= (cnt_nx != 2'd2);
      // s0 is always the head; s1 only fills when s0 is held.
      if (pop && cnt == 2'd2)
        s0 <= s1;
      else if (push && (cnt == 2'd0 || pop))
        s0 <= nw;
      if (push && !pop && cnt == 2'd1)
        s1 <= nw;
    end
  end

`ifdef BIN_DEC_STREAM_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      dec_cnt <= '0;
    else if (pop && !s0.err && dec_cnt != '1)
      dec_cnt <= dec_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_bin_dec_stream.sv
// Scoreboard bench for bin_dec_stream: three instances
// (OUT=16 high, OUT=10 high, OUT=16 low) share one stimulus.
module tb_bin_dec_stream;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in = 4'd0;
  logic       mode = 1'b0;
  logic       out_ready = 1'b0;

  logic        r16, v16, e16, r10, v10, e10, rlo, vlo, elo;
  logic [15:0] o16, olo;
  logic [9:0]  o10;
`ifdef BIN_DEC_STREAM_CNT_EN
  logic [15:0] c16, c10, clo;
  int          m_c16, m_c10, m_clo;
`endif

  int ncmp = 0;
  int nerr = 0;
  int m_cnt = 0;
  logic [4:0] sb[$];

  always #5 clk = ~clk;

  bin_dec_stream #(.IN(4), .OUT(16), .ACT(1'b1)) u16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r16),
    .in(in), .mode(mode), .out_valid(v16), .out_ready(out_ready),
    .out(o16), .out_err(e16)
`ifdef BIN_DEC_STREAM_CNT_EN
    , .dec_cnt(c16)
`endif
  );

  bin_dec_stream #(.IN(4), .OUT(10), .ACT(1'b1)) u10 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r10),
    .in(in), .mode(mode), .out_valid(v10), .out_ready(out_ready),
    .out(o10), .out_err(e10)
`ifdef BIN_DEC_STREAM_CNT_EN
    , .dec_cnt(c10)
`endif
  );

  bin_dec_stream #(.IN(4), .OUT(16), .ACT(1'b0)) ulo (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rlo),
    .in(in), .mode(mode), .out_valid(vlo), .out_ready(out_ready),
    .out(olo), .out_err(elo)
`ifdef BIN_DEC_STREAM_CNT_EN
    , .dec_cnt(clo)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Reference decode: {err, vector}, vector bits above w are zero.
  function automatic logic [16:0] model(input int w, input bit act,
                                        input logic [3:0] c,
                                        input bit m);
    logic [15:0] v;
    bit          e;
    v = '0;
    e = (int'(c) >= w);
    for (int i = 0; i < w; i++) begin
      if (!e) v[i] = m ? (i <= int'(c)) : (i == int'(c));
      if (!act) v[i] = ~v[i];
    end
    return {e, v};
  endfunction

  always @(negedge clk) begin
    logic [16:0] x16, x10, xlo;
    bit          ev, pop, push;
    if (reset) begin
      check("rst_rdy16", r16, 0);
      check("rst_val16", v16, 0);
      check("rst_out16", o16, 32'h0000);
      check("rst_err16", e16, 0);
      check("rst_val10", v10, 0);
      check("rst_outlo", olo, 32'hFFFF);
      check("rst_rdylo", rlo, 0);
      m_cnt = 0;
      sb.delete();
`ifdef BIN_DEC_STREAM_CNT_EN
      m_c16 = 0; m_c10 = 0; m_clo = 0;
`endif
    end else begin
      ev = (m_cnt != 0);
      check("rdy16", r16, (m_cnt != 2));
      check("rdy10", r10, (m_cnt != 2));
      check("rdylo", rlo, (m_cnt != 2));
      check("val16", v16, ev);
      check("val10", v10, ev);
      check("vallo", vlo, ev);
`ifdef BIN_DEC_STREAM_CNT_EN
      check("cnt16", c16, m_c16);
      check("cnt10", c10, m_c10);
      check("cntlo", clo, m_clo);
`endif
      if (ev && sb.size() == 0) begin
        check("sb_empty", sb.size(), 1);
      end else if (ev) begin
        x16 = model(16, 1, sb[0][4:1], sb[0][0]);
        x10 = model(10, 1, sb[0][4:1], sb[0][0]);
        xlo = model(16, 0, sb[0][4:1], sb[0][0]);
        check("out16", o16, x16[15:0]);
        check("err16", e16, x16[16]);
        check("out10", o10, x10[15:0]);
        check("err10", e10, x10[16]);
        check("outlo", olo, xlo[15:0]);
        check("errlo", elo, xlo[16]);
      end else begin
        check("idle16", o16, 32'h0000);
        check("idle10", o10, 32'h000);
        check("idlelo", olo, 32'hFFFF);
        check("idle_err", {e16, e10, elo}, 0);
      end
      pop  = ev && out_ready && sb.size() != 0;
      push = in_valid && (m_cnt != 2);
      if (pop) begin
`ifdef BIN_DEC_STREAM_CNT_EN
        if (!x16[16] && m_c16 != 16'hFFFF) m_c16++;
        if (!x10[16] && m_c10 != 16'hFFFF) m_c10++;
        if (!xlo[16] && m_clo != 16'hFFFF) m_clo++;
`endif
        void'(sb.pop_front());
        m_cnt--;
      end
      if (push) begin
        sb.push_back({in, mode});
        m_cnt++;
      end
    end
  end

  task automatic send(input logic [3:0] c, input bit m);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in = c;
    mode = m;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = r16;
      @(posedge clk);
      #1;
    end
    check("accept", ok, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
    #1;
    check("drain", sb.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    // Back-to-back one-hot sweep at full rate.
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) send(4'(c), 0);
    drain();
    // Thermometer, incl. out-of-range for OUT=10.
    send(4'd5, 1);
    send(4'd15, 1);
    send(4'd12, 1);
    send(4'd12, 0);
    send(4'd2, 0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    // Stall: 3 and 7 fill the FIFO, 9 waits for release.
    out_ready = 1'b0;
    send(4'd3, 0);
    send(4'd7, 0);
    fork
      send(4'd9, 0);
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    // Reset with two entries buffered.
    out_ready = 1'b0;
    send(4'd1, 0);
    send(4'd4, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(4'd6, 1);
    drain();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
